// File: rtl/mat_seq_control.sv
// Instruction sequencer for one matrix unit and its row cache: loadable program,
// fixed-latency SETW/MULT strobes, one level of counted loops.
// Optional perf counters are compiled in with MAT_SEQ_PERF_EN.
module mat_seq_control #(
  parameter int WIDTH        = 16,
  parameter int CACHE_SIZE   = 8,
  parameter int INST_DEPTH   = 32,
  parameter int UNIT_LATENCY = 16,
  localparam int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  localparam int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE),
  localparam int INST_ADDR_SIZE  = $clog2(INST_DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       inst_we_i,
  input  logic [INST_ADDR_SIZE-1:0]  inst_waddr_i,
  input  logic [27:0]                inst_wdata_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic                       cache_rd_en_o,
  output logic [CACHE_ADDR_SIZE-1:0] cache_rd_addr_o,
  output logic                       cache_wr_en_o,
  output logic [CACHE_ADDR_SIZE-1:0] cache_wr_addr_o,
  output logic                       unit_set_weight_o,
  output logic [WIDTH_ADDR_SIZE-1:0] unit_set_weight_row_o,
  output logic                       unit_valid_o
`ifdef MAT_SEQ_PERF_EN
  ,
  output logic [31:0]                perf_cycles_o,
  output logic [15:0]                perf_mults_o
`endif
);

  localparam int PCW = INST_ADDR_SIZE + 1;
  localparam int WCW = $clog2(UNIT_LATENCY + 1);
  localparam int IMEM = 1 << INST_ADDR_SIZE;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_SETW = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_LOOP = 4'd3;
  localparam logic [3:0] OP_HALT = 4'd4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_EXEC      = 3'd1;
  localparam logic [2:0] S_SETW2     = 3'd2;
  localparam logic [2:0] S_MULT_WAIT = 3'd3;
  localparam logic [2:0] S_MULT_WB   = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic           loop_act_q, loop_act_d;
  logic [7:0]     loop_cnt_q, loop_cnt_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           error_q, error_d;

  logic [27:0]    imem [IMEM];
  logic [27:0]    inst;
  logic [3:0]     op;
  logic [7:0]     fa, fb, fp;
  logic           pc_ovf, illegal, halt_ex, err_ex, mult_wb;
  logic [PCW-1:0] pc_inc;

  // Program memory: written only while idle, never reset.
  always_ff @(posedge clk_i) begin
    if (inst_we_i && state_q == S_IDLE && 32'(inst_waddr_i) < INST_DEPTH)
      imem[inst_waddr_i] <= inst_wdata_i;
  end

  assign inst   = imem[pc_q[INST_ADDR_SIZE-1:0]];
  assign op     = inst[3:0];
  assign fa     = inst[11:4];
  assign fb     = inst[19:12];
  assign fp     = inst[27:20];
  assign pc_inc = pc_q + PCW'(1);

  // Stepping past the last word leaves pc == INST_DEPTH; that fetch acts as an erroring HALT.
  assign pc_ovf  = (pc_q == PCW'(INST_DEPTH));
  assign illegal = (op > OP_HALT);
  assign halt_ex = (state_q == S_EXEC) && (pc_ovf || illegal || op == OP_HALT);
  assign err_ex  = (state_q == S_EXEC) && (pc_ovf || illegal);

  always_comb begin
    state_d               = state_q;
    pc_d                  = pc_q;
    loop_act_d            = loop_act_q;
    loop_cnt_d            = loop_cnt_q;
    wait_d                = wait_q;
    error_d               = error_q;
    done_o                = 1'b0;
    cache_rd_en_o         = 1'b0;
    cache_rd_addr_o       = '0;
    cache_wr_en_o         = 1'b0;
    cache_wr_addr_o       = '0;
    unit_set_weight_o     = 1'b0;
    unit_set_weight_row_o = '0;
    unit_valid_o          = 1'b0;
    mult_wb               = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_EXEC;
          pc_d       = '0;
          loop_act_d = 1'b0;
          loop_cnt_d = '0;
          error_d    = 1'b0;
        end
      end
      S_EXEC: begin
        if (halt_ex) begin
          // The halt-decode cycle is the done cycle.
          done_o     = 1'b1;
          state_d    = S_IDLE;
          pc_d       = '0;
          loop_act_d = 1'b0;
          if (err_ex) error_d = 1'b1;
        end else begin
          case (op)
            OP_NOP: pc_d = pc_inc;
            OP_SETW: begin
              cache_rd_en_o   = 1'b1;
              cache_rd_addr_o = fa[CACHE_ADDR_SIZE-1:0];
              state_d         = S_SETW2;
            end
            OP_MULT: begin
              cache_rd_en_o   = 1'b1;
              cache_rd_addr_o = fa[CACHE_ADDR_SIZE-1:0];
              wait_d          = '0;
              state_d         = S_MULT_WAIT;
            end
            OP_LOOP: begin
              if (loop_act_q) begin
                if (loop_cnt_q != 8'd0) begin
                  loop_cnt_d = loop_cnt_q - 8'd1;
                  pc_d       = PCW'(fa[INST_ADDR_SIZE-1:0]);
                end else begin
                  loop_act_d = 1'b0;
                  pc_d       = pc_inc;
                end
              end else if (fp != 8'd0) begin
                loop_act_d = 1'b1;
                loop_cnt_d = fp - 8'd1;
                pc_d       = PCW'(fa[INST_ADDR_SIZE-1:0]);
              end else begin
                pc_d = pc_inc;
              end
            end
            default: ;
          endcase
        end
      end
      S_SETW2: begin
        unit_set_weight_o     = 1'b1;
        unit_set_weight_row_o = fp[WIDTH_ADDR_SIZE-1:0];
        pc_d                  = pc_inc;
        state_d               = S_EXEC;
      end
      S_MULT_WAIT: begin
        // First wait cycle presents the vector; UNIT_LATENCY more cycles follow.
        unit_valid_o = (wait_q == '0);
        if (wait_q == WCW'(UNIT_LATENCY)) state_d = S_MULT_WB;
        else                              wait_d  = wait_q + WCW'(1);
      end
      S_MULT_WB: begin
        cache_wr_en_o   = 1'b1;
        cache_wr_addr_o = fb[CACHE_ADDR_SIZE-1:0];
        mult_wb         = 1'b1;
        pc_d            = pc_inc;
        state_d         = S_EXEC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE) && !halt_ex;
  assign error_o = error_q || err_ex;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      loop_act_q <= 1'b0;
      loop_cnt_q <= '0;
      wait_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_act_q <= loop_act_d;
      loop_cnt_q <= loop_cnt_d;
      wait_q     <= wait_d;
      error_q    <= error_d;
    end
  end

`ifdef MAT_SEQ_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [15:0] perf_mults_q;
  logic        start_acc;

  assign start_acc = (state_q == S_IDLE) && start_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_q <= '0;
      perf_mults_q  <= '0;
    end else if (start_acc) begin
      perf_cycles_q <= '0;
      perf_mults_q  <= '0;
    end else begin
      if (busy_o && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (mult_wb && perf_mults_q != '1) perf_mults_q <= perf_mults_q + 16'd1;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_mults_o  = perf_mults_q;
`endif

  logic unused_fields;
  assign unused_fields = ^{fa, fb, fp};

endmodule

// File: tb/tb_mat_seq_control.sv
// Directed + random program runs of mat_seq_control against an instruction-level
// timing model that expands each program into an expected per-cycle output trace.
module tb_mat_seq_control;
  localparam int LAT   = 16;
  localparam int DEPTH = 32;
  localparam int MAXC  = 2048;

  typedef struct packed {
    logic       busy, done, err, rd;
    logic [2:0] rda;
    logic       wr;
    logic [2:0] wra;
    logic       sw;
    logic [3:0] swr;
    logic       uv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_we, start;
  logic [4:0]  inst_waddr;
  logic [27:0] inst_wdata;
  logic        busy, done, error, rd_en, wr_en, set_w, uvalid;
  logic [2:0]  rd_addr, wr_addr;
  logic [3:0]  set_w_row;
`ifdef MAT_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_mults;
`endif

  mat_seq_control #(.WIDTH(16), .CACHE_SIZE(8), .INST_DEPTH(DEPTH), .UNIT_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .inst_we_i(inst_we), .inst_waddr_i(inst_waddr),
    .inst_wdata_i(inst_wdata), .start_i(start), .busy_o(busy), .done_o(done),
    .error_o(error), .cache_rd_en_o(rd_en), .cache_rd_addr_o(rd_addr),
    .cache_wr_en_o(wr_en), .cache_wr_addr_o(wr_addr), .unit_set_weight_o(set_w),
    .unit_set_weight_row_o(set_w_row), .unit_valid_o(uvalid)
`ifdef MAT_SEQ_PERF_EN
    , .perf_cycles_o(perf_cycles), .perf_mults_o(perf_mults)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [27:0] prog [DEPTH];
  vec_t        expv [MAXC];
  int          exp_d, exp_m, sw_seen;

  function automatic logic [27:0] mk(input int op, input int a, input int b, input int p);
    return {p[7:0], b[7:0], a[7:0], op[3:0]};
  endfunction

  function automatic vec_t obs();
    return {busy, done, error, rd_en, rd_addr, wr_en, wr_addr, set_w, set_w_row, uvalid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Instruction-level model: walks the program and stamps each strobe at its cycle.
  task automatic model();
    int t, pc, lc;
    bit la, hlt, err;
    logic [27:0] w;
    logic [7:0] a, b, p;
    for (int k = 0; k < MAXC; k++) expv[k] = '0;
    t = 1; pc = 0; la = 0; lc = 0; hlt = 0; err = 0; exp_m = 0;
    while (!hlt && t < MAXC - LAT - 8) begin
      if (pc >= DEPTH) begin err = 1; hlt = 1; end
      else begin
        w = prog[pc]; a = w[11:4]; b = w[19:12]; p = w[27:20];
        case (int'(w[3:0]))
          0: begin t++; pc++; end
          1: begin
            expv[t].rd = 1; expv[t].rda = a[2:0];
            expv[t+1].sw = 1; expv[t+1].swr = p[3:0];
            t += 2; pc++;
          end
          2: begin
            expv[t].rd = 1; expv[t].rda = a[2:0];
            expv[t+1].uv = 1;
            expv[t+2+LAT].wr = 1; expv[t+2+LAT].wra = b[2:0];
            t += 3 + LAT; pc++; exp_m++;
          end
          3: begin
            if (la) begin
              if (lc != 0) begin lc--; pc = int'(a) % DEPTH; end
              else begin la = 0; pc++; end
            end else if (p != 0) begin la = 1; lc = int'(p) - 1; pc = int'(a) % DEPTH; end
            else pc++;
            t++;
          end
          4: hlt = 1;
          default: begin err = 1; hlt = 1; end
        endcase
      end
    end
    exp_d = t;
    for (int k = 1; k < t; k++) expv[k].busy = 1;
    expv[t].done = 1; expv[t].err = err; expv[t+1].err = err;
  endtask

  task automatic load();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); inst_we = 1; inst_waddr = 5'(i); inst_wdata = prog[i];
    end
    @(negedge clk); inst_we = 0;
  endtask

  // Runs the loaded program; poke = start/inst_we while busy, samew = rewrite word 0 in the
  // start cycle, stop_at>0 = return early after that many cycles.
  task automatic run(input string name, input bit poke, input bit samew, input int stop_at);
    int lim;
    logic [27:0] neww;
    load();
    neww = mk(4, 0, 0, 0);
    if (samew) prog[0] = neww;
    model();
    lim = (stop_at > 0) ? stop_at : exp_d + 1;
    sw_seen = 0;
    @(negedge clk); start = 1;
    if (samew) begin inst_we = 1; inst_waddr = 0; inst_wdata = neww; end
    @(negedge clk); start = 0; inst_we = 0;
    for (int k = 1; k <= lim; k++) begin
      chk($sformatf("%s_c%0d", name, k), 32'(obs()), 32'(expv[k]));
      if (set_w) sw_seen++;
      start = poke && k == 2; inst_we = poke && k == 2;
      inst_waddr = 0; inst_wdata = mk(4, 0, 0, 0);
      @(negedge clk);
    end
    start = 0; inst_we = 0;
`ifdef MAT_SEQ_PERF_EN
    if (stop_at == 0) begin
      chk({name, "_perf_cyc"}, perf_cycles, 32'(exp_d - 1));
      chk({name, "_perf_mul"}, 32'(perf_mults), 32'(exp_m));
    end
`endif
  endtask

  task automatic fill_rand();
    for (int i = 0; i < DEPTH; i++)
      prog[i] = mk(int'($urandom_range(0, 2)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  initial begin
    int n;
    rst_n = 0; inst_we = 0; start = 0; inst_waddr = 0; inst_wdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(obs()), 32'h0);
`ifdef MAT_SEQ_PERF_EN
    chk("reset_perf", perf_cycles + 32'(perf_mults), 32'h0);
`endif
    rst_n = 1;

    fill_rand(); prog[0] = mk(1, 2, 0, 5); prog[1] = mk(4, 0, 0, 0);
    run("setw", 0, 0, 0);
    chk("setw_done_cyc", 32'(exp_d), 32'd3);

    fill_rand(); prog[0] = mk(2, 1, 3, 0); prog[1] = mk(4, 0, 0, 0);
    run("mult", 0, 0, 0);

    fill_rand(); prog[0] = mk(0, 0, 0, 0); prog[1] = mk(1, 0, 0, 0);
    prog[2] = mk(3, 1, 0, 3); prog[3] = mk(4, 0, 0, 0);
    run("loop", 0, 0, 0);
    chk("loop_sw_pulses", 32'(sw_seen), 32'd4);

    fill_rand(); prog[0] = mk(15, 0, 0, 0);
    run("illegal", 0, 0, 0);
    fill_rand(); prog[0] = mk(1, 7, 0, 9); prog[1] = mk(4, 0, 0, 0);
    run("errclr", 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) prog[i] = mk(0, 0, 0, 0);
    run("pcwrap", 0, 0, 0);

    fill_rand(); prog[0] = mk(2, 4, 6, 0); prog[1] = mk(1, 5, 0, 2);
    prog[2] = mk(2, 3, 1, 0); prog[3] = mk(4, 0, 0, 0);
    run("busypoke", 1, 0, 0);
    run("busypoke2", 0, 0, 0);

    fill_rand(); prog[0] = mk(1, 1, 1, 1); prog[1] = mk(4, 0, 0, 0);
    run("samew", 0, 1, 0);

    fill_rand(); prog[0] = mk(2, 1, 3, 0); prog[1] = mk(4, 0, 0, 0);
    run("rstmid", 0, 0, 8);
    #2 rst_n = 0;
    #1 chk("rst_async_outs", 32'(obs()), 32'h0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("rst_no_done", 32'(obs()), 32'h0);
`ifdef MAT_SEQ_PERF_EN
    chk("rst_perf", perf_cycles + 32'(perf_mults), 32'h0);
`endif
    run("rst_rerun", 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      fill_rand();
      n = int'($urandom_range(3, 10));
      prog[n-1] = mk(3, int'($urandom_range(0, n - 2)), 0, int'($urandom_range(0, 3)));
      prog[n] = ($urandom_range(0, 4) == 0) ? mk(int'($urandom_range(5, 15)), 0, 0, 0)
                                            : mk(4, 0, 0, 0);
      run($sformatf("rand%0d", r), r[0], 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
